instr_fetch_responder: RTL and testbench
========================================

Name: instr_fetch_responder

Overview:
- Consumer end of the program-counter fetch interface. Accepts fetch addresses from the PC, reads a synchronous instruction memory with 1-cycle read latency, and buffers the returned words in a small FIFO.
- Hands instructions to decode through a valid/ready handshake.
- Sits between the program counter and the decode stage. Supports flush on a taken branch.

Parameters:
- ADDR_W, 16, width of the fetch address; matches PC count width.
- DATA_W, 32, instruction word width.
- DEPTH, 4, instruction FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  PC presents a fetch address
- req_ready  output  1  block can accept a fetch this cycle
- req_addr  input  ADDR_W  byte address of the instruction
- flush  input  1  taken branch; discard all fetched and in-flight words
- mem_en  output  1  instruction memory read strobe
- mem_addr  output  ADDR_W  instruction memory byte address
- mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_en
- instr_valid  output  1  FIFO head holds an instruction
- instr_ready  input  1  decode consumes the head this cycle
- instr_data  output  DATA_W  instruction word at the FIFO head
- instr_addr  output  ADDR_W  fetch address of the head instruction
- occupancy  output  $clog2(DEPTH)+1  FIFO entries plus in-flight read

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers = 0, occupancy = 0, pending flag = 0.
  - instr_valid = 0, instr_data = 0, instr_addr = 0.
  - req_ready = 0 while reset is asserted. After release it is 1 from the first clock edge.
- Request acceptance:
  - req_ready = !flush && (fifo_count + pending) < DEPTH.
  - Fire = req_valid && req_ready.
  - mem_en = fire and mem_addr = req_addr, both combinational in the same cycle. Otherwise mem_en = 0 and mem_addr holds its last value.
- Pending stage:
  - On fire, pending <= 1 and pend_addr <= req_addr. Otherwise pending <= 0.
  - Cycle after fire: if pending and not flush, push {pend_addr, mem_rdata} into the FIFO.
- Latency: request accepted in cycle N with FIFO empty -> instr_valid = 1 in cycle N+2.
- Throughput: 1 instruction per cycle sustained when instr_ready is held at 1.
- Pop: instr_valid && instr_ready advances the read pointer. Push and pop in the same cycle leave the count unchanged.
- Full:
  - The credit check guarantees a push never overflows: pending counts against capacity.
  - With the FIFO at DEPTH entries and no pop, req_ready = 0.
  - A pop in a full cycle frees one credit; req_ready rises the next cycle, with no combinational path from instr_ready to req_ready.
- Empty: instr_valid = 0. instr_data and instr_addr hold their last values.
- Pointers: wrap modulo DEPTH; the count is kept explicitly.
- Flush (synchronous, one cycle):
  - FIFO count and pointers reset to 0 and pending is cleared.
  - The memory word returning that cycle is dropped.
  - req_ready = 0 during the flush cycle.
  - Next cycle instr_valid = 0 and requests are accepted again, normally at the branch target.
  - Flush coincident with a pop: flush wins; the pop is still counted as consumed by decode.
- Reset mid-operation: all in-flight and buffered words are discarded immediately, with no memory strobe after reset asserts.
- Occupancy = fifo_count + pending, registered view.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - Adds output instr_err (1 bit), stored per FIFO entry and reset to 0.
  - instr_err = 1 for an entry whose req_addr[1:0] != 0.
  - The memory read still occurs, with mem_addr[1:0] forced to 0.
- Undefined: no instr_err port; addresses pass through unmodified.

Test Plan:
- Reset release, then req_addr = 0x0000, 0x0004, 0x0008 on consecutive cycles with instr_ready = 1 and memory returning 0x11111111, 0x22222222, 0x33333333 -> instr_valid rises 2 cycles after the first fire; words come out in order with instr_addr 0, 4, 8, one per cycle.
- instr_ready = 0 with continuous requests, DEPTH = 4 -> exactly 4 fires, then req_ready = 0 and occupancy = 4. Raising instr_ready for 1 cycle -> one pop, and req_ready = 1 the next cycle.
- Flush asserted 1 cycle after fire of 0x0010 while the FIFO holds 2 entries -> the word for 0x0010 is dropped, occupancy = 0, and instr_valid = 0 the next cycle. The next request 0x0040 returns with instr_addr = 0x0040.
- Flush in the same cycle as instr_valid && instr_ready and a pending req_valid -> no fire (mem_en = 0), FIFO empty afterwards.
- reset driven low asynchronously mid-burst, between clock edges -> instr_valid, occupancy and req_ready go to 0 immediately; mem_en = 0 until release.
- With FETCH_MISALIGN_CHECK_EN defined, req_addr = 0x0006 -> mem_addr = 0x0004 and instr_err = 1 with instr_addr = 0x0006. A following 0x0008 gives instr_err = 0.

Source files
------------

// File: rtl/instr_fetch_responder_if.sv
// Bundle of fetch-request, instruction-memory and decode-handshake signals for
// instr_fetch_responder. FETCH_MISALIGN_CHECK_EN adds the instr_err signal.
interface instr_fetch_responder_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              flush;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_addr;
    logic [OCC_W-1:0]  occupancy;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic              instr_err;

    modport slave (
        input  req_valid, req_addr, flush, mem_rdata, instr_ready,
        output req_ready, mem_en, mem_addr, instr_valid, instr_data, instr_addr, occupancy,
               instr_err
    );
    modport master (
        output req_valid, req_addr, flush, mem_rdata, instr_ready,
        input  req_ready, mem_en, mem_addr, instr_valid, instr_data, instr_addr, occupancy,
               instr_err
    );
`else
    modport slave (
        input  req_valid, req_addr, flush, mem_rdata, instr_ready,
        output req_ready, mem_en, mem_addr, instr_valid, instr_data, instr_addr, occupancy
    );
    modport master (
        output req_valid, req_addr, flush, mem_rdata, instr_ready,
        input  req_ready, mem_en, mem_addr, instr_valid, instr_data, instr_addr, occupancy
    );
`endif
endinterface

// File: rtl/instr_fetch_responder.sv
// Accepts PC fetches, reads a 1-cycle-latency instruction memory and queues {addr, word} for
// decode. Define FETCH_MISALIGN_CHECK_EN to flag and word-align misaligned fetches (instr_err).
module instr_fetch_responder #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input logic                    clk,
    input logic                    reset,
    instr_fetch_responder_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic              live_q;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pending_q, pending_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0] fifo_data_q [DEPTH];
    logic [ADDR_W-1:0] fifo_addr_q [DEPTH];

    logic [CNT_W-1:0]  credits;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fire, push, pop, head_valid;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic req_err;
    logic pend_err_q, pend_err_d;
    logic hold_err_q, hold_err_d;
    logic fifo_err_q [DEPTH];

    assign req_err    = |bus.req_addr[1:0];
    assign fetch_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};
`else
    assign fetch_addr = bus.req_addr;
`endif

    // The in-flight read holds a credit so a returning word always has a slot.
    assign credits       = count_q + CNT_W'(pending_q);
    assign head_valid    = (count_q != '0);
    assign bus.req_ready = live_q && !bus.flush && (credits < CNT_W'(DEPTH));
    assign fire          = bus.req_valid && bus.req_ready;
    assign push          = pending_q && !bus.flush;
    assign pop           = head_valid && bus.instr_ready;

    assign bus.mem_en      = fire;
    assign bus.mem_addr    = fire ? fetch_addr : mem_addr_q;
    assign bus.instr_valid = head_valid;
    assign bus.instr_data  = head_valid ? fifo_data_q[rd_ptr_q] : hold_data_q;
    assign bus.instr_addr  = head_valid ? fifo_addr_q[rd_ptr_q] : hold_addr_q;
    assign bus.occupancy   = credits;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign bus.instr_err   = head_valid ? fifo_err_q[rd_ptr_q] : hold_err_q;
`endif

    always_comb begin
        pending_d   = fire;
        pend_addr_d = fire ? bus.req_addr : pend_addr_q;
        mem_addr_d  = bus.mem_addr;
        hold_data_d = bus.instr_data;
        hold_addr_d = bus.instr_addr;
`ifdef FETCH_MISALIGN_CHECK_EN
        pend_err_d  = fire ? req_err : pend_err_q;
        hold_err_d  = bus.instr_err;
`endif
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (bus.flush) begin
            // A pop in the flush cycle is consumed by decode, then everything is discarded.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pending_q   <= 1'b0;
            pend_addr_q <= '0;
            mem_addr_q  <= '0;
            hold_data_q <= '0;
            hold_addr_q <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            pend_err_q  <= 1'b0;
            hold_err_q  <= 1'b0;
`endif
        end else begin
            live_q      <= 1'b1;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            pend_addr_q <= pend_addr_d;
            mem_addr_q  <= mem_addr_d;
            hold_data_q <= hold_data_d;
            hold_addr_q <= hold_addr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            pend_err_q  <= pend_err_d;
            hold_err_q  <= hold_err_d;
`endif
        end
    end

    // Storage is only read when count_q marks the slot valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= bus.mem_rdata;
            fifo_addr_q[wr_ptr_q] <= pend_addr_q;
`ifdef FETCH_MISALIGN_CHECK_EN
            fifo_err_q[wr_ptr_q]  <= pend_err_q;
`endif
        end
    end
endmodule

// File: tb/tb_instr_fetch_responder.sv
// Scoreboard bench for instr_fetch_responder: stimulus pushes expected {addr, word} on each
// accepted fetch, a negedge monitor pops and compares on every decode handshake.
module tb_instr_fetch_responder;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;

    instr_fetch_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    instr_fetch_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: mem_word = 32'h11111111;
            16'h0004: mem_word = 32'h22222222;
            16'h0008: mem_word = 32'h33333333;
            default:  mem_word = {16'hC0DE, a};
        endcase
    endfunction

    // Synchronous memory: data appears the cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        bus.mem_rdata <= bus.mem_en ? mem_word(bus.mem_addr) : 32'hDEADBEEF;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.instr_valid && bus.instr_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_instr: got addr=%0h data=%0h expected none",
                         bus.instr_addr, bus.instr_data);
            end else begin
                mon_e = sb.pop_front();
                chk("instr_addr", 64'(bus.instr_addr), 64'(mon_e.addr));
                chk("instr_data", 64'(bus.instr_data), 64'(mon_e.data));
`ifdef FETCH_MISALIGN_CHECK_EN
                chk("instr_err", 64'(bus.instr_err), 64'(mon_e.err));
`endif
            end
        end
        if (bus.flush) sb.delete();
    end

    // One bench cycle: inputs change just after posedge, acceptance is judged after negedge.
    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] maddr,
                         input logic [31:0] d, input logic e, input logic rdy, input logic fl,
                         output logic fired);
        exp_t x;
        @(posedge clk);
        #1;
        bus.req_valid   = v;
        bus.req_addr    = a;
        bus.instr_ready = rdy;
        bus.flush       = fl;
        @(negedge clk);
        #1;
        fired = bus.req_valid && bus.req_ready;
        if (fired) begin
            chk("mem_en", 64'(bus.mem_en), 64'h1);
            chk("mem_addr", 64'(bus.mem_addr), 64'(maddr));
            x.addr = a;
            x.data = d;
            x.err  = e;
            sb.push_back(x);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic        f;
        int          nf;
        logic [15:0] a;

        reset           = 1'b0;
        bus.req_valid   = 1'b1;
        bus.req_addr    = 16'h1234;
        bus.flush       = 1'b0;
        bus.instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
        chk("rst_mem_en", 64'(bus.mem_en), 64'h0);
        chk("rst_instr_valid", 64'(bus.instr_valid), 64'h0);
        chk("rst_occupancy", 64'(bus.occupancy), 64'h0);
        chk("rst_instr_data", 64'(bus.instr_data), 64'h0);
        chk("rst_instr_addr", 64'(bus.instr_addr), 64'h0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("release_req_ready", 64'(bus.req_ready), 64'h0);
        @(posedge clk);
        #1;
        chk("first_edge_req_ready", 64'(bus.req_ready), 64'h1);

        // In-order burst, 2-cycle latency, one per cycle, head holds when empty.
        drive(1, 16'h0000, 16'h0000, 32'h11111111, 0, 1, 0, f);
        chk("burst_fire0", 64'(f), 64'h1);
        chk("lat_valid_n", 64'(bus.instr_valid), 64'h0);
        drive(1, 16'h0004, 16'h0004, 32'h22222222, 0, 1, 0, f);
        chk("burst_fire1", 64'(f), 64'h1);
        chk("lat_valid_n1", 64'(bus.instr_valid), 64'h0);
        drive(1, 16'h0008, 16'h0008, 32'h33333333, 0, 1, 0, f);
        chk("burst_fire2", 64'(f), 64'h1);
        chk("lat_valid_n2", 64'(bus.instr_valid), 64'h1);
        drive(0, 16'h0000, 16'h0000, 32'h0, 0, 1, 0, f);
        chk("stream_valid_3", 64'(bus.instr_valid), 64'h1);
        drive(0, 16'h0000, 16'h0000, 32'h0, 0, 1, 0, f);
        chk("stream_valid_4", 64'(bus.instr_valid), 64'h1);
        drive(0, 16'h0000, 16'h0000, 32'h0, 0, 1, 0, f);
        chk("empty_valid", 64'(bus.instr_valid), 64'h0);
        chk("hold_data", 64'(bus.instr_data), 64'h33333333);
        chk("hold_addr", 64'(bus.instr_addr), 64'h0008);

        // Fill with decode stalled: pending read counts against capacity.
        a  = 16'h0100;
        nf = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, a, a, {16'hC0DE, a}, 0, 0, 0, f);
            if (f) begin
                nf++;
                a = a + 16'h4;
            end
        end
        chk("full_fires", 64'(nf), 64'd4);
        chk("full_req_ready", 64'(bus.req_ready), 64'h0);
        chk("full_occupancy", 64'(bus.occupancy), 64'd4);
        drive(1, 16'h0110, 16'h0110, 32'hC0DE0110, 0, 1, 0, f);
        chk("pop_cycle_no_fire", 64'(f), 64'h0);
        drive(1, 16'h0110, 16'h0110, 32'hC0DE0110, 0, 0, 0, f);
        chk("after_pop_fire", 64'(f), 64'h1);
        repeat (7) drive(0, 16'h0000, 16'h0000, 32'h0, 0, 1, 0, f);

        // Flush one cycle after a fire with two entries buffered.
        drive(1, 16'h0020, 16'h0020, 32'hC0DE0020, 0, 0, 0, f);
        drive(1, 16'h0024, 16'h0024, 32'hC0DE0024, 0, 0, 0, f);
        drive(0, 16'h0000, 16'h0000, 32'h0, 0, 0, 0, f);
        chk("pre_flush_occ", 64'(bus.occupancy), 64'd2);
        drive(1, 16'h0010, 16'h0010, 32'hC0DE0010, 0, 0, 0, f);
        chk("pre_flush_fire", 64'(f), 64'h1);
        drive(1, 16'h0040, 16'h0040, 32'hC0DE0040, 0, 0, 1, f);
        chk("flush_no_fire", 64'(f), 64'h0);
        chk("flush_req_ready", 64'(bus.req_ready), 64'h0);
        drive(1, 16'h0040, 16'h0040, 32'hC0DE0040, 0, 0, 0, f);
        chk("post_flush_valid", 64'(bus.instr_valid), 64'h0);
        chk("post_flush_occ", 64'(bus.occupancy), 64'h0);
        chk("target_fire", 64'(f), 64'h1);
        repeat (4) drive(0, 16'h0000, 16'h0000, 32'h0, 0, 1, 0, f);

        // Flush together with a pop and a pending request.
        drive(1, 16'h0050, 16'h0050, 32'hC0DE0050, 0, 0, 0, f);
        drive(0, 16'h0000, 16'h0000, 32'h0, 0, 0, 0, f);
        drive(1, 16'h0060, 16'h0060, 32'hC0DE0060, 0, 1, 1, f);
        chk("flush_pop_no_fire", 64'(f), 64'h0);
        chk("flush_pop_mem_en", 64'(bus.mem_en), 64'h0);
        drive(0, 16'h0000, 16'h0000, 32'h0, 0, 0, 0, f);
        chk("flush_pop_valid", 64'(bus.instr_valid), 64'h0);
        chk("flush_pop_occ", 64'(bus.occupancy), 64'h0);

        // Asynchronous reset between edges while words are in flight.
        drive(1, 16'h0070, 16'h0070, 32'hC0DE0070, 0, 0, 0, f);
        drive(1, 16'h0074, 16'h0074, 32'hC0DE0074, 0, 0, 0, f);
        @(posedge clk);
        #1;
        bus.req_valid   = 1'b1;
        bus.req_addr    = 16'h0078;
        bus.instr_ready = 1'b0;
        #2;
        chk("pre_reset_occ", 64'(bus.occupancy), 64'd2);
        chk("pre_reset_valid", 64'(bus.instr_valid), 64'h1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.instr_valid), 64'h0);
        chk("mid_rst_occ", 64'(bus.occupancy), 64'h0);
        chk("mid_rst_req_ready", 64'(bus.req_ready), 64'h0);
        chk("mid_rst_mem_en", 64'(bus.mem_en), 64'h0);
        chk("mid_rst_data", 64'(bus.instr_data), 64'h0);
        sb.delete();
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("in_rst_mem_en", 64'(bus.mem_en), 64'h0);
        end
        @(negedge clk);
        reset         = 1'b1;
        bus.req_valid = 1'b0;

        // Misaligned fetch: flagged and word-aligned when the check is built in.
`ifdef FETCH_MISALIGN_CHECK_EN
        drive(1, 16'h0006, 16'h0004, 32'h22222222, 1, 1, 0, f);
`else
        drive(1, 16'h0006, 16'h0006, 32'hC0DE0006, 0, 1, 0, f);
`endif
        chk("misalign_fire", 64'(f), 64'h1);
        drive(1, 16'h0008, 16'h0008, 32'h33333333, 0, 1, 0, f);
        chk("aligned_fire", 64'(f), 64'h1);
        repeat (4) drive(0, 16'h0000, 16'h0000, 32'h0, 0, 1, 0, f);
        chk("final_hold_addr", 64'(bus.instr_addr), 64'h0008);
        chk("sb_empty", 64'(sb.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
